// File: rtl/double_div_operand_feeder.sv
// double_div_operand_feeder: FIFO-buffers dividend/divisor pairs and feeds them to the divider's two-phase strobe/ack input.
module double_div_operand_feeder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [63:0]              in_a,
    input  logic [63:0]              in_b,
    output logic [63:0]              div_a,
    output logic                     div_a_stb,
    input  logic                     div_a_ack,
    output logic [63:0]              div_b,
    output logic                     div_b_stb,
    input  logic                     div_b_ack,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         issued
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, SEND_A = 2'd1, SEND_B = 2'd2;
    logic [1:0]    state;
    logic [AW-1:0] wptr, rptr;
    logic [63:0]   mem_a [DEPTH];
    logic [63:0]   mem_b [DEPTH];
    logic          push, pop;
    assign in_ready = level != (AW+1)'(DEPTH);
    assign push     = in_valid && in_ready;
    assign pop      = state == SEND_B && div_b_stb && div_b_ack;
    assign div_a    = mem_a[rptr];
    assign div_b    = mem_b[rptr];
    // Storage is reset too so the head outputs never show X while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            state     <= IDLE;
            div_a_stb <= 1'b0;
            div_b_stb <= 1'b0;
            issued    <= '0;
        end else begin
            if (push) begin
                mem_a[wptr] <= in_a;
                mem_b[wptr] <= in_b;
                wptr        <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (state == IDLE && level != '0) begin
                state     <= SEND_A;
                div_a_stb <= 1'b1;
            end else if (state == SEND_A && div_a_ack) begin
                state     <= SEND_B;
                div_a_stb <= 1'b0;
                div_b_stb <= 1'b1;
            end else if (pop) begin
                state     <= IDLE;
                div_b_stb <= 1'b0;
                issued    <= issued + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_double_div_operand_feeder.sv
// tb_double_div_operand_feeder: directed checks of the operand feeder FIFO and strobe/ack sequencing.
module tb_double_div_operand_feeder;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0, in_ready;
    logic [63:0] in_a = 0, in_b = 0, div_a, div_b;
    logic        div_a_stb, div_b_stb;
    logic        div_a_ack = 0, div_b_ack = 0;
    logic [2:0]  level;
    logic [31:0] issued;
    int          n_cmp = 0, n_bad = 0;

    double_div_operand_feeder #(.DEPTH(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .div_a(div_a), .div_a_stb(div_a_stb),
        .div_a_ack(div_a_ack), .div_b(div_b), .div_b_stb(div_b_stb),
        .div_b_ack(div_b_ack), .level(level), .issued(issued)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 0;
        div_a_ack = 0;
        div_b_ack = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // Acts as the divider: waits for the a strobe, acks after da cycles, then b after db cycles.
    task automatic serve(input int da, input int db, input logic [63:0] ea, input logic [63:0] eb);
        int t = 0;
        while (!div_a_stb && t < 60) begin
            tick();
            t++;
        end
        chk("a_stb_wait", div_a_stb, 1);
        chk("a_data", div_a, ea);
        chk("b_off_in_a", div_b_stb, 0);
        repeat (da) begin
            tick();
            chk("a_stb_hold", div_a_stb, 1);
            chk("a_data_hold", div_a, ea);
            chk("b_off_in_a", div_b_stb, 0);
        end
        div_a_ack = 1;
        tick();
        div_a_ack = 0;
        chk("a_stb_fall", div_a_stb, 0);
        chk("b_stb_rise", div_b_stb, 1);
        chk("b_data", div_b, eb);
        repeat (db) begin
            tick();
            chk("b_stb_hold", div_b_stb, 1);
            chk("b_data_hold", div_b, eb);
            chk("a_off_in_b", div_a_stb, 0);
        end
        div_b_ack = 1;
        tick();
        div_b_ack = 0;
        chk("b_stb_fall", div_b_stb, 0);
    endtask

    initial begin
        #2;
        chk("rst_level", level, 0);
        chk("rst_a_stb", div_a_stb, 0);
        chk("rst_b_stb", div_b_stb, 0);
        chk("rst_issued", issued, 0);
        chk("rst_ready", in_ready, 1);
        do_reset();

        // single pair with acks tied high
        div_a_ack = 1;
        div_b_ack = 1;
        in_a = 64'h4000000000000000;
        in_b = 64'h3FF0000000000000;
        in_valid = 1;
        tick();
        in_valid = 0;
        chk("single_lvl1", level, 1);
        chk("single_no_stb_yet", div_a_stb, 0);
        tick();
        chk("single_a_stb", div_a_stb, 1);
        chk("single_a", div_a, 64'h4000000000000000);
        tick();
        chk("single_a_fall", div_a_stb, 0);
        chk("single_b_stb", div_b_stb, 1);
        chk("single_b", div_b, 64'h3FF0000000000000);
        tick();
        chk("single_b_fall", div_b_stb, 0);
        chk("single_issued", issued, 1);
        chk("single_level", level, 0);
        div_a_ack = 0;
        div_b_ack = 0;

        // fill: 5 offered, 4 accepted
        for (int i = 0; i < 5; i++) begin
            in_a = 64'h1000 + 64'(i);
            in_b = 64'h2000 + 64'(i);
            in_valid = 1;
            chk("fill_ready", in_ready, (i < 4) ? 1 : 0);
            tick();
        end
        in_valid = 0;
        chk("fill_level", level, 4);
        chk("fill_ready_low", in_ready, 0);
        repeat (3) begin
            chk("fill_a_stb", div_a_stb, 1);
            chk("fill_a", div_a, 64'h1000);
            tick();
        end
        // delayed acks on pair 0, then drain the rest
        serve(7, 12, 64'h1000, 64'h2000);
        chk("after_delay_level", level, 3);
        for (int i = 1; i < 4; i++) serve(0, 0, 64'h1000 + 64'(i), 64'h2000 + 64'(i));
        tick();
        chk("fill_drained", level, 0);
        chk("fill_issued", issued, 5);

        // simultaneous push/pop at level 2
        for (int i = 0; i < 2; i++) begin
            in_a = 64'h3000 + 64'(i);
            in_b = 64'h4000 + 64'(i);
            in_valid = 1;
            tick();
        end
        in_valid = 0;
        chk("sim_level2", level, 2);
        chk("sim_a_stb", div_a_stb, 1);
        div_a_ack = 1;
        tick();
        div_a_ack = 0;
        chk("sim_b_stb", div_b_stb, 1);
        in_a = 64'h3002;
        in_b = 64'h4002;
        in_valid = 1;
        div_b_ack = 1;
        tick();
        in_valid = 0;
        div_b_ack = 0;
        chk("sim_level_hold", level, 2);
        chk("sim_issued", issued, 6);
        serve(1, 1, 64'h3001, 64'h4001);
        serve(0, 2, 64'h3002, 64'h4002);

        // wrap-around stream with random ack delays
        do_reset();
        fork
            for (int i = 0; i < 10; i++) begin
                int t = 0;
                in_a = 64'hA5A5000000000000 + 64'(i);
                in_b = 64'h5A5A000000000000 + 64'(i);
                in_valid = 1;
                while (!in_ready && t < 300) begin
                    tick();
                    t++;
                end
                tick();
                in_valid = 0;
                repeat ($urandom_range(0, 2)) tick();
            end
            for (int i = 0; i < 10; i++)
                serve($urandom_range(0, 4), $urandom_range(0, 4),
                      64'hA5A5000000000000 + 64'(i), 64'h5A5A000000000000 + 64'(i));
        join
        tick();
        chk("wrap_issued", issued, 10);
        chk("wrap_level", level, 0);

        // reset in SEND_B with level 3
        div_a_ack = 1;
        for (int i = 0; i < 3; i++) begin
            in_a = 64'h7000 + 64'(i);
            in_b = 64'h8000 + 64'(i);
            in_valid = 1;
            tick();
        end
        in_valid = 0;
        div_a_ack = 0;
        chk("mid_b_stb", div_b_stb, 1);
        chk("mid_level3", level, 3);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_b_stb", div_b_stb, 0);
        chk("mid_rst_a_stb", div_a_stb, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_issued", issued, 0);
        @(posedge clk);
        #3 rst_n = 1;
        repeat (5) begin
            tick();
            chk("post_rst_quiet", {div_a_stb, div_b_stb}, 0);
        end
        in_a = 64'h9000;
        in_b = 64'h9001;
        in_valid = 1;
        tick();
        in_valid = 0;
        serve(0, 0, 64'h9000, 64'h9001);
        tick();
        chk("post_rst_issued", issued, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
